// File: rtl/soc_bus_arbiter.sv
// soc_bus_arbiter: round-robin multi-master to decoded-slave bus arbiter, one transaction in flight.
// Define SOC_BUS_TIMEOUT_EN to bound how long a granted request may wait on its slave.

module soc_bus_addr_match #(
    parameter int               XLEN = 32,
    parameter logic [XLEN-1:0]  BASE = '0,
    parameter logic [XLEN-1:0]  MASK = '0
) (
    input  logic [XLEN-1:0] addr,
    output logic            hit
);
    assign hit = (addr & MASK) == BASE;
endmodule

module soc_bus_arbiter #(
    parameter int                          XLEN           = 32,
    parameter int                          NUM_MASTERS    = 2,
    parameter int                          NUM_SLAVES     = 5,
    parameter logic [NUM_SLAVES*XLEN-1:0]  SLAVE_BASE     = {32'h0000_0000, 32'h0C00_0000, 32'h8000_0000,
                                                             32'h1000_0000, 32'h0200_0000},
    parameter logic [NUM_SLAVES*XLEN-1:0]  SLAVE_MASK     = {32'hFFFF_C000, 32'hFF00_0000, 32'hFFFF_C000,
                                                             32'hFFFF_FFF8, 32'hFFFF_0000},
    parameter logic [7:0]                  TIMEOUT_CYCLES = 8'd255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_MASTERS-1:0]      master_req_valid,
    input  logic [NUM_MASTERS*XLEN-1:0] master_req_addr,
    input  logic [NUM_MASTERS*64-1:0]   master_req_wdata,
    input  logic [NUM_MASTERS-1:0]      master_req_we,
    input  logic [NUM_MASTERS*3-1:0]    master_req_size,
    output logic [NUM_MASTERS-1:0]      master_req_ready,
    output logic [NUM_MASTERS-1:0]      master_req_err,
    output logic [63:0]                 master_req_rdata,
    output logic [NUM_SLAVES-1:0]       slave_req_valid,
    output logic [XLEN-1:0]             slave_req_addr,
    output logic [63:0]                 slave_req_wdata,
    output logic                        slave_req_we,
    output logic [2:0]                  slave_req_size,
    input  logic [NUM_SLAVES-1:0]       slave_req_ready,
    input  logic [NUM_SLAVES*64-1:0]    slave_req_rdata,
    output logic [2:0]                  grant_id
);

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [63:0]     wdata;
        logic            we;
        logic [2:0]      size;
    } req_t;

    state_t                 state_q, state_d;
    req_t                   req_q, pick_req;
    logic [2:0]             rr_ptr_q, grant_q, sel_q, pick, rr_nxt, dec_sel;
    logic                   any_valid, dec_hit, err_q, sel_rdy, tmo_hit;
    logic [63:0]            rdata_q, sel_rdata;
    logic [NUM_SLAVES-1:0]  slave_hit;

    // Round-robin: offset k=0 from rr_ptr has top priority, so it is evaluated last.
    always_comb begin
        any_valid = 1'b0;
        pick      = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (master_req_valid[i] && ((int'(rr_ptr_q) + k) % NUM_MASTERS) == i) begin
                    any_valid = 1'b1;
                    pick      = 3'(i);
                end
            end
        end
    end

    assign rr_nxt = (int'(pick) == NUM_MASTERS - 1) ? 3'd0 : pick + 3'd1;

    always_comb begin
        pick_req = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick == 3'(i)) begin
                pick_req.addr  = master_req_addr[i*XLEN +: XLEN];
                pick_req.wdata = master_req_wdata[i*64 +: 64];
                pick_req.we    = master_req_we[i];
                pick_req.size  = master_req_size[i*3 +: 3];
            end
        end
    end

    for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_dec
        soc_bus_addr_match #(
            .XLEN (XLEN),
            .BASE (SLAVE_BASE[s*XLEN +: XLEN]),
            .MASK (SLAVE_MASK[s*XLEN +: XLEN])
        ) u_match (
            .addr (pick_req.addr),
            .hit  (slave_hit[s])
        );
    end

    // Overlapping windows resolve to the lowest slave index.
    always_comb begin
        dec_hit = |slave_hit;
        dec_sel = '0;
        for (int s = NUM_SLAVES - 1; s >= 0; s--) begin
            if (slave_hit[s]) dec_sel = 3'(s);
        end
    end

    always_comb begin
        sel_rdy   = 1'b0;
        sel_rdata = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            if (sel_q == 3'(s)) begin
                sel_rdy   = slave_req_ready[s];
                sel_rdata = slave_req_rdata[s*64 +: 64];
            end
        end
    end

`ifdef SOC_BUS_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               tmo_cnt_q <= '0;
        else if (state_q == ACTIVE && !sel_rdy)  tmo_cnt_q <= tmo_cnt_q + 8'd1;
        else                                     tmo_cnt_q <= '0;
    end

    assign tmo_hit = (state_q == ACTIVE) && !sel_rdy && (tmo_cnt_q == TIMEOUT_CYCLES - 8'd1);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign tmo_hit        = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        slave_req_valid  = '0;
        master_req_ready = '0;
        master_req_err   = '0;
        master_req_rdata = '0;
        case (state_q)
            IDLE:    if (any_valid) state_d = dec_hit ? ACTIVE : RESP;
            ACTIVE: begin
                for (int s = 0; s < NUM_SLAVES; s++) slave_req_valid[s] = (sel_q == 3'(s));
                if (sel_rdy || tmo_hit) state_d = RESP;
            end
            RESP: begin
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    master_req_ready[i] = (grant_q == 3'(i));
                    master_req_err[i]   = (grant_q == 3'(i)) && err_q;
                end
                master_req_rdata = rdata_q;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q    <= '0;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            sel_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (any_valid) begin
                    req_q    <= pick_req;
                    grant_q  <= pick;
                    rr_ptr_q <= rr_nxt;
                    sel_q    <= dec_sel;
                    err_q    <= !dec_hit;
                    rdata_q  <= '0;
                end
                ACTIVE: if (sel_rdy) begin
                    rdata_q <= sel_rdata;
                    err_q   <= 1'b0;
                end else if (tmo_hit) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign slave_req_addr  = req_q.addr;
    assign slave_req_wdata = req_q.wdata;
    assign slave_req_we    = req_q.we;
    assign slave_req_size  = req_q.size;
    assign grant_id        = grant_q;

endmodule

// File: doc/soc_bus_arbiter.md
SOC_BUS_ARBITER -- requirements
Module: soc_bus_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32: address width.
REQ-002 SHALL have parameter NUM_MASTERS, default 2: requesting masters, range 1..8.
REQ-003 SHALL have parameter NUM_SLAVES, default 5: decoded slaves, range 1..8.
REQ-004 SHALL have parameter SLAVE_BASE, default {0x0000_0000, 0x0C00_0000, 0x8000_0000, 0x1000_0000, 0x0200_0000} (slave4..slave0): NUM_SLAVES*XLEN flattened base addresses.
REQ-005 SHALL have parameter SLAVE_MASK, default {0xFFFF_C000, 0xFF00_0000, 0xFFFF_C000, 0xFFFF_FFF8, 0xFFFF_0000}: NUM_SLAVES*XLEN flattened match masks.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 255: slave wait limit, 8-bit.
REQ-007 clk  input  1  single clock, rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 master_req_valid  input  NUM_MASTERS  per-master request.
REQ-010 master_req_addr  input  NUM_MASTERS*XLEN  per-master address.
REQ-011 master_req_wdata  input  NUM_MASTERS*64  per-master write data.
REQ-012 master_req_we  input  NUM_MASTERS  per-master write enable.
REQ-013 master_req_size  input  NUM_MASTERS*3  per-master access size.
REQ-014 master_req_ready  output  NUM_MASTERS  one-cycle completion pulse.
REQ-015 master_req_err  output  NUM_MASTERS  error qualifier, valid with ready.
REQ-016 master_req_rdata  output  64  shared read data, valid with ready.
REQ-017 slave_req_valid  output  NUM_SLAVES  one-hot slave select.
REQ-018 slave_req_addr / _wdata / _we / _size  output  XLEN/64/1/3  shared latched request.
REQ-019 slave_req_ready  input  NUM_SLAVES  slave completion.
REQ-020 slave_req_rdata  input  NUM_SLAVES*64  per-slave read data.
REQ-021 grant_id  output  3  index of currently granted master (debug).

Function
REQ-022 FSM states IDLE, ACTIVE, RESP; one transaction in flight.
REQ-023 IDLE: any master_req_valid -> round-robin pick starting at rr_ptr; latch addr, wdata, we, size, grant_id; decode slave; go ACTIVE (decode hit) or RESP with err (miss).
REQ-024 Decode: slave i hits when (addr & MASK_i) == BASE_i; multiple hits -> lowest index wins.
REQ-025 rr_ptr SHALL become (granted index + 1) mod NUM_MASTERS on every grant.
REQ-026 ACTIVE: slave_req_valid[sel] high, all other bits low; on slave_req_ready[sel] latch slave_req_rdata[sel] -> RESP, err=0.
REQ-027 RESP: master_req_ready[grant_id] high exactly one cycle with latched rdata/err; -> IDLE.
REQ-028 Minimum latency: request seen in IDLE at cycle N, slave ready in cycle N+1 -> master ready in cycle N+2.
REQ-029 Decode miss: master ready in cycle N+1 with err=1, rdata=0; no slave_req_valid asserted.
REQ-030 Masters SHALL hold valid and request fields until ready; changes mid-transaction are ignored (latched copy used).
REQ-031 Non-granted masters' ready/err SHALL be 0; rdata SHALL be 0 outside RESP.
REQ-032 A master re-asserting valid in the cycle after its ready competes normally in IDLE (no back-to-back starvation of others due to rr_ptr).
REQ-033 NUM_MASTERS=1 SHALL degenerate to pass-through with fixed grant 0.

Reset
REQ-034 reset SHALL asynchronously force IDLE, rr_ptr=0, grant_id=0, timeout counter=0, latched fields=0.
REQ-035 During and after reset all outputs 0; an in-flight transaction is dropped with no ready pulse.

Configuration
REQ-036 Macro SOC_BUS_TIMEOUT_EN defined: ACTIVE counter increments per cycle from 0; reaching TIMEOUT_CYCLES without slave ready -> RESP with err=1, rdata=0; slave_req_valid deasserts.
REQ-037 Macro SOC_BUS_TIMEOUT_EN undefined: no counter; ACTIVE waits indefinitely; err only on decode miss.

Verification
REQ-038 M0 read 0x8000_0010, slave2 ready next cycle with rdata 0x1122_3344_5566_7788 -> M0 ready 2 cycles after request, rdata matches, err=0.
REQ-039 M0 and M1 both valid from reset, repeated reads to 0x0200_0000 -> grants alternate 0,1,0,1.
REQ-040 M1 write 0x4000_0000 (unmapped) -> M1 ready next cycle, err=1, no slave_req_valid.
REQ-041 With SOC_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave1 never ready for 0x1000_0000 -> M0 ready with err=1 after 4 ACTIVE cycles; without macro, ready never asserts.
REQ-042 Assert reset while ACTIVE to slave3 -> all outputs 0 immediately, next request granted to M0.
REQ-043 Overlapping slaves (BASE 0, MASK 0 on slave4) with address 0x0200_0008 -> slave0 selected.
